// File: rtl/store_narrow_buffer.sv
// -----------------------------------------------------------------------------
// store_narrow_buffer
//
// Formats narrow (byte / half / word) stores from the MEM stage into
// word-aligned, lane-replicated memory writes with byte enables, and queues
// them in a small FIFO ahead of data memory.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : store request present
//   in_ready   : buffer can accept a request (occupancy < DEPTH)
//   in_addr    : store byte address
//   in_data    : register value to store (low bits used for byte/half)
//   in_size    : 00 byte, 01 half, 10 word, 11 illegal
//   mem_valid  : head entry presented to memory (== !empty)
//   mem_ready  : memory accepts the head entry this cycle
//   mem_addr   : word address of head entry (bits [1:0] are 00)
//   mem_wdata  : lane-replicated write data of head entry
//   mem_be     : byte enables of head entry, bit i = byte lane i
//   align_err  : one-cycle pulse after a rejected (misaligned/illegal) request
//   empty      : buffer holds no entries
//
// DEPTH must be 2, 4 or 8 (power of two so the pointers wrap naturally).
// -----------------------------------------------------------------------------
module store_narrow_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        align_err,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          align_err_reg;

    logic [31:0]   addr_mem  [DEPTH];
    logic [31:0]   wdata_mem [DEPTH];
    logic [3:0]    be_mem    [DEPTH];

    logic [31:0]   fmt_wdata;
    logic [3:0]    fmt_be;
    logic          fmt_bad;
    logic          accept;
    logic          enq;
    logic          deq;

    // Request formatting: replicate the narrow value into every lane so the
    // byte enables alone select where it lands in the word.
    always_comb begin
        fmt_wdata = in_data;
        fmt_be    = 4'b0000;
        fmt_bad   = 1'b0;
        case (in_size)
            2'b00: begin
                fmt_wdata = {4{in_data[7:0]}};
                fmt_be    = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                fmt_wdata = {2{in_data[15:0]}};
                fmt_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                fmt_bad   = in_addr[0];
            end
            2'b10: begin
                fmt_wdata = in_data;
                fmt_be    = 4'b1111;
                fmt_bad   = |in_addr[1:0];
            end
            default: begin
                fmt_bad   = 1'b1;
            end
        endcase
    end

    // No bypass when full: a dequeue in the same cycle does not open a slot
    // for the incoming request until the following cycle.
    assign in_ready = (count_reg < CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    // Rejected requests are consumed (handshake completes) but never stored.
    assign enq      = accept && !fmt_bad;
    assign deq      = (count_reg != '0) && mem_ready;

    // Storage: one register set per entry, written only when the write
    // pointer selects it. Cleared on reset so mem_* read back as zero.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    addr_mem[gi]  <= '0;
                    wdata_mem[gi] <= '0;
                    be_mem[gi]    <= '0;
                end else if (enq && (wr_ptr_reg == PW'(gi))) begin
                    addr_mem[gi]  <= {in_addr[31:2], 2'b00};
                    wdata_mem[gi] <= fmt_wdata;
                    be_mem[gi]    <= fmt_be;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            align_err_reg <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            align_err_reg <= accept && fmt_bad;
        end
    end

    // Head entry outputs come straight from stored state; nothing from in_*
    // reaches mem_* without passing through a register.
    assign mem_addr  = addr_mem[rd_ptr_reg];
    assign mem_wdata = wdata_mem[rd_ptr_reg];
    assign mem_be    = be_mem[rd_ptr_reg];
    assign mem_valid = (count_reg != '0);
    assign empty     = (count_reg == '0);
    assign align_err = align_err_reg;

endmodule

// File: tb/tb_store_narrow_buffer.sv
module tb_store_narrow_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        align_err;
    logic        empty;

    store_narrow_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .in_size   (in_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .align_err (align_err),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Expected response for the request currently driven on in_*.
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_err;

    logic        acc_pend = 1'b0;
    logic        acc_err  = 1'b0;
    logic        err_exp  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Scoreboard push: the handshake seen on the preceding falling edge
    // completes on this rising edge.
    always @(posedge clk) begin
        if (rst_n) begin
            err_exp = acc_pend && acc_err;
            if (acc_pend && !acc_err) begin
                exp_q.push_back('{addr: exp_addr, wdata: exp_wdata, be: exp_be});
            end
        end
    end

    // Monitor: compare head of DUT with head of scoreboard, pop on dequeue.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t f;
            chk("occupancy_empty", {31'd0, empty}, {31'd0, exp_q.size() == 0});
            chk("mem_valid", {31'd0, mem_valid}, {31'd0, exp_q.size() != 0});
            chk("align_err", {31'd0, align_err}, {31'd0, err_exp});
            if (exp_q.size() > DEPTH) begin
                checks++;
                errors++;
                $display("FAIL overflow actual=%0d required<=%0d", exp_q.size(), DEPTH);
            end
            if (mem_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=0x%08h required=none", mem_addr);
                end else begin
                    f = exp_q[0];
                    chk("mem_addr", mem_addr, f.addr);
                    chk("mem_wdata", mem_wdata, f.wdata);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, f.be});
                    if (mem_ready) begin
                        void'(exp_q.pop_front());
                        $display("write addr=0x%08h wdata=0x%08h be=%b", mem_addr, mem_wdata, mem_be);
                    end
                end
            end
            acc_pend = in_valid && in_ready;
            acc_err  = exp_err;
        end else begin
            acc_pend = 1'b0;
        end
    end

    task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] eb,
                           input logic ee);
        in_addr   = a;
        in_data   = d;
        in_size   = s;
        exp_addr  = ea;
        exp_wdata = ew;
        exp_be    = eb;
        exp_err   = ee;
        in_valid  = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] eb,
                        input logic ee);
        logic ok;
        ok = 1'b0;
        set_req(a, d, s, ea, ew, eb, ee);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=stalled required=accepted addr=0x%08h", a);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("store addr=0x%08h data=0x%08h size=%b err=%b", a, d, s, ee);
    endtask

    task automatic wait_empty();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (empty && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = 32'hFFFF_FFFF;
        in_data   = 32'hFFFF_FFFF;
        in_size   = 2'b10;
        mem_ready = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_be    = '0;
        exp_err   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_align_err", {31'd0, align_err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SB to lane 3, visible the cycle after acceptance
        mem_ready = 1'b1;
        send(32'h0000_1003, 32'h1234_56AB, 2'b00, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000, 1'b0);
        @(negedge clk);
        chk("sb_latency_valid", {31'd0, mem_valid}, 32'd1);
        @(posedge clk);
        #1;
        wait_empty();

        // SH upper half, then misaligned SW
        send(32'h0000_2002, 32'h0000_BEEF, 2'b01, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 1'b0);
        wait_empty();
        send(32'h0000_2001, 32'h1111_2222, 2'b10, 32'h0, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk("sw_mis_err", {31'd0, align_err}, 32'd1);
        chk("sw_mis_valid", {31'd0, mem_valid}, 32'd0);
        chk("sw_mis_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("sw_mis_err_drop", {31'd0, align_err}, 32'd0);
        @(posedge clk);
        #1;

        // Illegal size at aligned address, misaligned half
        send(32'h0000_3000, 32'h0000_0001, 2'b11, 32'h0, 32'h0, 4'h0, 1'b1);
        @(negedge clk);
        chk("size11_err", {31'd0, align_err}, 32'd1);
        chk("size11_empty", {31'd0, empty}, 32'd1);
        @(posedge clk);
        #1;
        send(32'h0000_3001, 32'h0000_0002, 2'b01, 32'h0, 32'h0, 4'h0, 1'b1);

        // Other lanes: SB lane 0 and 1, SH lower half, aligned SW
        send(32'h0000_4000, 32'hFFFF_FF55, 2'b00, 32'h0000_4000, 32'h5555_5555, 4'b0001, 1'b0);
        send(32'h0000_4001, 32'h0000_00C3, 2'b00, 32'h0000_4000, 32'hC3C3_C3C3, 4'b0010, 1'b0);
        send(32'h0000_4000, 32'hCAFE_1234, 2'b01, 32'h0000_4000, 32'h1234_1234, 4'b0011, 1'b0);
        send(32'h0000_4004, 32'hDEAD_BEEF, 2'b10, 32'h0000_4004, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        wait_empty();

        // Fill with memory stalled, fifth request waits
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(32'(i * 4), 32'h0A00_0000 + 32'(i), 2'b10,
                 32'(i * 4), 32'h0A00_0000 + 32'(i), 4'b1111, 1'b0);
        end
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        set_req(32'h0000_0010, 32'h0A00_0004, 2'b10, 32'h0000_0010, 32'h0A00_0004, 4'b1111, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("after_deq_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_empty();

        // Sustained streaming from full, pointers wrap repeatedly
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(32'h0000_0100 + 32'(i * 4), 32'hA500_0000 + 32'(i), 2'b10,
                 32'h0000_0100 + 32'(i * 4), 32'hA500_0000 + 32'(i), 4'b1111, 1'b0);
        end
        mem_ready = 1'b1;
        for (int i = 4; i < 24; i++) begin
            send(32'h0000_0100 + 32'(i * 4), 32'hA500_0000 + 32'(i), 2'b10,
                 32'h0000_0100 + 32'(i * 4), 32'hA500_0000 + 32'(i), 4'b1111, 1'b0);
        end
        wait_empty();

        // Asynchronous reset with three entries queued
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'h0000_0200 + 32'(i * 4), 32'h5A00_0000 + 32'(i), 2'b10,
                 32'h0000_0200 + 32'(i * 4), 32'h5A00_0000 + 32'(i), 4'b1111, 1'b0);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        err_exp = 1'b0;
        #1;
        chk("arst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_mem_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", {31'd0, empty}, 32'd1);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Recovery after reset
        mem_ready = 1'b1;
        send(32'h0000_0302, 32'h0000_7E7E, 2'b00, 32'h0000_0300, 32'h7E7E_7E7E, 4'b0100, 1'b0);
        wait_empty();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_narrow_buffer.md
STORE_NARROW_BUFFER -- requirements
Module: store_narrow_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning store-buffer entries; legal values are 2, 4 and 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a store request from the MEM stage is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the buffer can accept a request this cycle.
REQ-006 The block SHALL have port in_addr, input, 32 bits: store byte address.
REQ-007 The block SHALL have port in_data, input, 32 bits: register value to store; only low bits are used for byte/half.
REQ-008 The block SHALL have port in_size, input, 2 bits: 00 byte (SB), 01 half (SH), 10 word (SW), 11 illegal.
REQ-009 The block SHALL have port mem_valid, output, 1 bit: a formatted write is presented to data memory.
REQ-010 The block SHALL have port mem_ready, input, 1 bit: memory accepts the write this cycle.
REQ-011 The block SHALL have port mem_addr, output, 32 bits: word address, with bits [1:0] forced to 00.
REQ-012 The block SHALL have port mem_wdata, output, 32 bits: lane-replicated write data.
REQ-013 The block SHALL have port mem_be, output, 4 bits: byte enables, where bit i enables byte lane i (little-endian).
REQ-014 The block SHALL have port align_err, output, 1 bit: one-cycle pulse flagging a rejected request.
REQ-015 The block SHALL have port empty, output, 1 bit: the buffer holds no entries.

Function
REQ-016 Handshake: a request SHALL be accepted exactly on a rising edge where in_valid and in_ready are both 1; in_ready SHALL be 1 iff occupancy < DEPTH (no same-cycle full bypass).
REQ-017 Byte store: the entry SHALL hold wdata = {4{in_data[7:0]}} and be = 0001 shifted left by in_addr[1:0].
REQ-018 Half store: the entry SHALL hold wdata = {2{in_data[15:0]}} and be = 0011 if in_addr[1]=0, else 1100; in_addr[0]=1 is misaligned.
REQ-019 Word store: the entry SHALL hold wdata = in_data and be = 1111; in_addr[1:0] != 00 is misaligned.
REQ-020 A misaligned or size-11 request SHALL be accepted (consumed) but not enqueued, and align_err SHALL be 1 for exactly the following cycle.
REQ-021 The buffer SHALL be a FIFO; mem_addr, mem_wdata and mem_be SHALL be driven from registered head-entry state, with no combinational path from in_* to mem_*.
REQ-022 Latency: an entry accepted at edge N SHALL first be visible with mem_valid=1 in the cycle after edge N (minimum one cycle, including when the buffer is empty).
REQ-023 mem_valid SHALL equal !empty; while mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_be SHALL hold stable.
REQ-024 The head SHALL be dequeued on an edge where mem_valid=1 and mem_ready=1.
REQ-025 A simultaneous enqueue and dequeue SHALL leave occupancy unchanged.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a separate counter of width log2(DEPTH)+1.
REQ-027 Entry order SHALL be strictly preserved, and no entry SHALL be merged, dropped or duplicated.

Reset
REQ-028 While rst_n=0: pointers and occupancy SHALL be 0, in_ready=1, mem_valid=0, empty=1, align_err=0, and mem_addr, mem_wdata and mem_be SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL immediately discard all entries and any pending align_err pulse, without waiting for a clock edge.
REQ-030 The first request accepted SHALL be on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-031 SB addr=0x1003, data=0x123456AB, mem_ready=1: next cycle mem_addr=0x1000, mem_wdata=0xABABABAB, mem_be=1000, then empty=1.
REQ-032 SH addr=0x2002, data=0x0000BEEF: mem_wdata=0xBEEFBEEF, mem_be=1100; SW addr=0x2001: no mem_valid, align_err high for exactly 1 cycle, in_ready stays 1.
REQ-033 With mem_ready=0, issue 4 SW (addr 0x0, 0x4, 0x8, 0xC): in_ready=0 after the 4th; a 5th request is stalled; raise mem_ready: writes emerge in order 0x0, 0x4, 0x8, 0xC, and the 5th is accepted the cycle after the first dequeue.
REQ-034 Full buffer with mem_ready=1 and in_valid=1 held: one enqueue per cycle after the first drain, occupancy never exceeds 4, and pointers wrap with no data corruption over 20 stores.
REQ-035 Reset pulsed low asynchronously with 3 entries queued: mem_valid drops in the same cycle, and after release empty=1 and in_ready=1.
REQ-036 in_size=11 at an aligned address: align_err pulse, nothing enqueued.
